// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Slave end of the load/store unit's data-memory request interface. Holds a
//   DEPTH x XLEN word array. Each accepted request (read, write, or both) gets
//   exactly one `hit` pulse LAT cycles after the accept edge. Writes commit on
//   the accept edge using byte-lane strobes. Reads sample the array at accept,
//   so they see the pre-write contents, and return the strobed lanes
//   right-aligned on `mem_res`.
//
//   Build option: define DMEM_ERR_EN to add the `err` port. Illegal strobe
//   patterns and out-of-range addresses then flag an error: the write is
//   dropped and the read returns zero. Without the macro, strobes are raw lane
//   enables and addresses wrap modulo DEPTH.
//
// Ports
//   clk         clock
//   rst_n       synchronous, active-low reset
//   r_v / w_v   read / write request valid (both high = write, read-before-write)
//   req_adr     byte address; word index = req_adr[log2(DEPTH)+1:2]
//   req_data    lane-aligned write data
//   req_strobe  byte-lane enables
//   req_rdy     idle; a valid request is accepted on this edge
//   hit         one-cycle response pulse
//   mem_res     read data (RES_W bits), valid with hit, zero otherwise
//   err         (DMEM_ERR_EN only) error flag, valid with hit
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 256,
  parameter int LAT   = 2,
  parameter int RES_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r_v,
  input  logic             w_v,
  input  logic [XLEN-1:0]  req_adr,
  input  logic [XLEN-1:0]  req_data,
  input  logic [3:0]       req_strobe,
  output logic             req_rdy,
  output logic             hit,
  output logic [RES_W-1:0] mem_res
`ifdef DMEM_ERR_EN
  ,
  output logic             err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             req_rdy_q;
  logic             hit_q;
  logic [RES_W-1:0] mem_res_q;
  logic [RES_W-1:0] res_hold_q;

  logic [XLEN-1:0]  mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational pre-decode of the presented request
  // ---------------------------------------------------------------------------
  logic [AW-1:0]    idx;
  logic             accept;
  logic [1:0]       low_lane;
  logic [XLEN-1:0]  lane_mask;
  logic [XLEN-1:0]  rd_shifted;
  logic [RES_W-1:0] res_d;
  logic             req_err;
  logic             wr_en;

  assign idx    = req_adr[AW+1:2];
  assign accept = rst_n && (state_q == S_IDLE) && (r_v || w_v);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    low_lane  = 2'd0;
    lane_mask = '0;
    if      (req_strobe[0]) low_lane = 2'd0;
    else if (req_strobe[1]) low_lane = 2'd1;
    else if (req_strobe[2]) low_lane = 2'd2;
    else if (req_strobe[3]) low_lane = 2'd3;
    for (int k = 0; k < 4; k++) begin
      lane_mask[8*k +: 8] = {8{req_strobe[k]}};
    end
  end

  // Masking then shifting down by the lowest enabled lane gives the byte,
  // halfword or low word the initiator asked for, right-aligned, zero-filled.
  assign rd_shifted = (mem_q[idx] & lane_mask) >> {low_lane, 3'b000};

`ifdef DMEM_ERR_EN
  logic strobe_legal;
  logic adr_oor;
  logic err_q;
  logic err_hold_q;
  logic unused_adr;

  always_comb begin
    case (req_strobe)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b0110, 4'b1100, 4'b1111: strobe_legal = 1'b1;
      default:                            strobe_legal = 1'b0;
    endcase
  end

  assign adr_oor    = |req_adr[XLEN-1:AW+2];
  assign req_err    = !strobe_legal || adr_oor;
  assign unused_adr = ^req_adr[1:0];
  assign err        = err_q;
`else
  logic unused_adr;

  assign req_err    = 1'b0;
  assign unused_adr = ^{req_adr[XLEN-1:AW+2], req_adr[1:0]};
`endif

  assign res_d = req_err ? '0 : rd_shifted[RES_W-1:0];
  assign wr_en = accept && w_v && !req_err;

  // ---------------------------------------------------------------------------
  // Storage array, written on the accept edge
  // ---------------------------------------------------------------------------
  // NOTE: the array is deliberately not reset; only control state is. Resetting
  // storage would turn it into flops and lose data committed before reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (req_strobe[k]) mem_q[idx][8*k +: 8] <= req_data[8*k +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_rdy_q  <= 1'b1;
      hit_q      <= 1'b0;
      mem_res_q  <= '0;
      res_hold_q <= '0;
`ifdef DMEM_ERR_EN
      err_q      <= 1'b0;
      err_hold_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          hit_q     <= 1'b0;
          mem_res_q <= '0;
`ifdef DMEM_ERR_EN
          err_q     <= 1'b0;
`endif
          if (r_v || w_v) begin
            req_rdy_q  <= 1'b0;
            cnt_q      <= CW'(LAT - 1);
            res_hold_q <= res_d;
`ifdef DMEM_ERR_EN
            err_hold_q <= req_err;
`endif
            if (LAT == 1) begin
              state_q   <= S_RESP;
              hit_q     <= 1'b1;
              mem_res_q <= res_d;
`ifdef DMEM_ERR_EN
              err_q     <= req_err;
`endif
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q   <= S_RESP;
            hit_q     <= 1'b1;
            mem_res_q <= res_hold_q;
`ifdef DMEM_ERR_EN
            err_q     <= err_hold_q;
`endif
          end
        end
        S_RESP: begin
          state_q   <= S_IDLE;
          req_rdy_q <= 1'b1;
          hit_q     <= 1'b0;
          mem_res_q <= '0;
`ifdef DMEM_ERR_EN
          err_q     <= 1'b0;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_rdy = req_rdy_q;
  assign hit     = hit_q;
  assign mem_res = mem_res_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Self-checking bench for dmem_responder (LAT=2, DEPTH=256, RES_W=16).
//   A word-array reference model predicts every response from the behavioural
//   rules: lowest enabled lane, right-aligned lanes, read-before-write, and
//   (with DMEM_ERR_EN) error suppression. Directed scenarios come first,
//   followed by a full-array preload and a randomized traffic run.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r_v, w_v;
  logic [31:0] req_adr, req_data;
  logic [3:0]  req_strobe;
  logic        req_rdy, hit;
  logic [15:0] mem_res;
`ifdef DMEM_ERR_EN
  logic        err;
`endif

  int tests  = 0;
  int failed = 0;

  logic [31:0] model [DEPTH];

  dmem_responder #(.XLEN(32), .DEPTH(DEPTH), .LAT(LAT), .RES_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .r_v        (r_v),
    .w_v        (w_v),
    .req_adr    (req_adr),
    .req_data   (req_data),
    .req_strobe (req_strobe),
    .req_rdy    (req_rdy),
    .hit        (hit),
    .mem_res    (mem_res)
`ifdef DMEM_ERR_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  // Each enabled lane k lands at byte position (k - lowest enabled lane) of the
  // result; anything beyond 16 bits is dropped.
  function automatic logic [15:0] model_lanes(input logic [31:0] word, input logic [3:0] strb);
    logic [15:0] res = '0;
    int l = -1;
    for (int k = 3; k >= 0; k--) if (strb[k]) l = k;
    if (l >= 0) begin
      for (int k = l; k < 4; k++) begin
        if (strb[k] && (k - l) < 2) res[(k - l)*8 +: 8] = word[8*k +: 8];
      end
    end
    return res;
  endfunction

  function automatic logic model_err(input logic [31:0] adr, input logic [3:0] strb);
`ifdef DMEM_ERR_EN
    return !(strb inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                          4'b0011, 4'b0110, 4'b1100, 4'b1111}) || (adr >= DEPTH*4);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_write(input logic [31:0] adr, input logic [31:0] data, input logic [3:0] strb);
    int i = int'(adr[9:2]);
    for (int k = 0; k < 4; k++) if (strb[k]) model[i][8*k +: 8] = data[8*k +: 8];
  endtask

  // ---------------------------------------------------------------------------
  // Driving helpers (entered and left on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic idle_inputs;
    r_v = 1'b0; w_v = 1'b0; req_adr = '0; req_data = '0; req_strobe = '0;
  endtask

  task automatic wait_rdy;
    int n = 0;
    while (req_rdy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      tests++; failed++;
      $display("FAIL wait_rdy: req_rdy=%b after %0d cycles, required 1", req_rdy, n);
    end
  endtask

  // One complete transaction, checked against the model: latency, data, error
  // flag, single-cycle pulse and return to ready.
  task automatic run_txn(input logic r, input logic w, input logic [31:0] adr,
                         input logic [31:0] data, input logic [3:0] strb,
                         input string name, output logic [15:0] got_res, output logic got_err);
    logic [15:0] e_res;
    logic        e_err;
    int          lat  = 1;
    bit          seen = 0;
    e_err   = model_err(adr, strb);
    e_res   = e_err ? 16'h0 : model_lanes(model[adr[9:2]], strb);
    got_res = 'x;
    got_err = 1'b0;
    wait_rdy();
    r_v = r; w_v = w; req_adr = adr; req_data = data; req_strobe = strb;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    if (w && !e_err) model_write(adr, data, strb);
    while (lat <= LAT + 4) begin
      if (hit === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    tests++;
    if (!seen || lat != LAT) begin
      failed++;
      $display("FAIL %s latency: hit after %0d cycles (seen=%0b), required %0d", name, lat, seen, LAT);
    end
    if (seen) begin
      got_res = mem_res;
`ifdef DMEM_ERR_EN
      got_err = err;
      tests++;
      if (err !== e_err) begin
        failed++;
        $display("FAIL %s err: got %b, required %b", name, err, e_err);
      end
`endif
      tests++;
      if (mem_res !== e_res) begin
        failed++;
        $display("FAIL %s mem_res: got %h, required %h", name, mem_res, e_res);
      end
    end
    @(negedge clk);
    tests++;
    if (hit !== 1'b0 || req_rdy !== 1'b1) begin
      failed++;
      $display("FAIL %s after-hit: hit=%b req_rdy=%b, required hit=0 req_rdy=1", name, hit, req_rdy);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (req_rdy !== 1'b1 || hit !== 1'b0 || mem_res !== 16'h0) begin
      failed++;
      $display("FAIL reset_hold: rdy=%b hit=%b res=%h, required 1/0/0000", req_rdy, hit, mem_res);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (req_rdy !== 1'b1 || hit !== 1'b0 || mem_res !== 16'h0) begin
        failed++;
        $display("FAIL reset_idle[%0d]: rdy=%b hit=%b res=%h, required 1/0/0000", i, req_rdy, hit, mem_res);
      end
    end
  endtask

  task automatic test_write_read;
    logic [15:0] res;
    logic        e;
    run_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, "wr_word", res, e);
    run_txn(1'b1, 1'b0, 32'h10, 32'h0, 4'b0011, "rd_half", res, e);
    tests++;
    if (res !== 16'hBEEF) begin
      failed++;
      $display("FAIL rd_half_const: got %h, required BEEF", res);
    end
  endtask

  task automatic test_byte_lanes;
    logic [15:0] res;
    logic        e;
    run_txn(1'b0, 1'b1, 32'h13, 32'h5A000000, 4'b1000, "wr_byte3", res, e);
    run_txn(1'b1, 1'b0, 32'h13, 32'h0, 4'b1000, "rd_byte3", res, e);
    tests++;
    if (res !== 16'h005A) begin
      failed++;
      $display("FAIL rd_byte3_const: got %h, required 005A", res);
    end
    run_txn(1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, "rd_word", res, e);
    tests++;
    if (res !== 16'hBEEF) begin
      failed++;
      $display("FAIL rd_word_const: got %h, required BEEF", res);
    end
    run_txn(1'b1, 1'b0, 32'h12, 32'h0, 4'b1100, "rd_hi_half", res, e);
    tests++;
    if (res !== 16'h5AAD) begin
      failed++;
      $display("FAIL rd_hi_half_const: got %h, required 5AAD", res);
    end
  endtask

  task automatic test_rw_both;
    logic [15:0] res;
    logic        e;
    run_txn(1'b1, 1'b1, 32'h10, 32'h11223344, 4'b1111, "rw_both", res, e);
    tests++;
    if (res !== 16'hBEEF) begin
      failed++;
      $display("FAIL rw_both_const: got %h, required BEEF", res);
    end
    run_txn(1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, "rd_after_rw", res, e);
    tests++;
    if (res !== 16'h3344) begin
      failed++;
      $display("FAIL rd_after_rw_const: got %h, required 3344", res);
    end
  endtask

  // A write presented while busy must be dropped: one hit only, and the target
  // word keeps its earlier contents.
  task automatic test_busy_drop;
    logic [15:0] res;
    logic        e;
    int          hits   = 0;
    int          hit_at = -1;
    logic        rdy_after = 1'bx;
    run_txn(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 4'b1111, "wr_busy_target", res, e);
    wait_rdy();
    r_v = 1'b1; req_adr = 32'h10; req_strobe = 4'b0011;
    @(posedge clk);
    for (int i = 1; i <= LAT + 4; i++) begin
      @(negedge clk);
      if (hit === 1'b1) begin
        hits++;
        hit_at = i;
      end
      if (hit_at >= 0 && i == hit_at + 1) rdy_after = req_rdy;
      if (i == 1) begin
        r_v = 1'b0; w_v = 1'b1; req_adr = 32'h40; req_data = 32'h0; req_strobe = 4'b1111;
      end else if (i == 2) begin
        idle_inputs();
      end
    end
    tests++;
    if (hits != 1 || hit_at != LAT) begin
      failed++;
      $display("FAIL busy_hits: %0d hits, first at %0d, required 1 at %0d", hits, hit_at, LAT);
    end
    tests++;
    if (rdy_after !== 1'b1) begin
      failed++;
      $display("FAIL busy_rdy_after_hit: got %b, required 1", rdy_after);
    end
    run_txn(1'b1, 1'b0, 32'h40, 32'h0, 4'b1111, "rd_busy_target", res, e);
    tests++;
    if (res !== 16'hF00D) begin
      failed++;
      $display("FAIL busy_target_const: got %h, required F00D", res);
    end
  endtask

  // Reset asserted in WAIT: no hit, but the write committed at accept stays.
  task automatic test_reset_mid;
    logic [15:0] res;
    logic        e;
    logic [31:0] d = $urandom;
    int          hits = 0;
    wait_rdy();
    w_v = 1'b1; req_adr = 32'h80; req_data = d; req_strobe = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    model_write(32'h80, d, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (hit === 1'b1) hits++;
      if (i == 1) rst_n = 1'b1;
    end
    tests++;
    if (hits != 0 || req_rdy !== 1'b1) begin
      failed++;
      $display("FAIL reset_mid: %0d hits, req_rdy=%b, required 0 hits, req_rdy=1", hits, req_rdy);
    end
    run_txn(1'b1, 1'b0, 32'h80, 32'h0, 4'b1111, "rd_after_reset", res, e);
    tests++;
    if (res !== d[15:0]) begin
      failed++;
      $display("FAIL rd_after_reset_const: got %h, required %h", res, d[15:0]);
    end
  endtask

`ifdef DMEM_ERR_EN
  task automatic test_err;
    logic [15:0] res;
    logic        e;
    run_txn(1'b0, 1'b1, 32'h20, 32'h01020304, 4'b1111, "err_setup", res, e);
    run_txn(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0101, "err_strobe", res, e);
    tests++;
    if (e !== 1'b1) begin
      failed++;
      $display("FAIL err_strobe_const: err=%b, required 1", e);
    end
    run_txn(1'b1, 1'b0, 32'h20, 32'h0, 4'b1111, "err_nowrite", res, e);
    tests++;
    if (res !== 16'h0304) begin
      failed++;
      $display("FAIL err_nowrite_const: got %h, required 0304", res);
    end
    run_txn(1'b1, 1'b0, 32'h420, 32'h0, 4'b1111, "err_oor", res, e);
  endtask
`endif

  task automatic test_preload;
    logic [15:0] res;
    logic        e;
    for (int i = 0; i < DEPTH; i++) begin
      run_txn(1'b0, 1'b1, 32'(i*4), $urandom, 4'b1111, "preload", res, e);
    end
  endtask

  task automatic test_random;
    logic [15:0] res;
    logic        e;
    logic [3:0]  legal [9] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hF};
    for (int n = 0; n < 200; n++) begin
      int          op  = $urandom_range(0, 2);
      logic [31:0] adr = 32'($urandom_range(0, DEPTH*4 - 1));
      logic [3:0]  strb;
      if ($urandom_range(0, 4) == 0) adr = adr | ($urandom << 10);
      if (op == 1 && $urandom_range(0, 3) == 0) strb = 4'($urandom_range(0, 15));
      else strb = legal[$urandom_range(0, 8)];
      run_txn(op != 1, op != 0, adr, $urandom, strb, "random", res, e);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_rw_both();
    test_busy_drop();
    test_reset_mid();
`ifdef DMEM_ERR_EN
    test_err();
`endif
    test_preload();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
